// File: rtl/bn_mul_sched_if.sv
// Requester-side and multiplier-side signals of the shared-multiplier scheduler.
// slave is the scheduler view; master is the view of whatever surrounds it.
interface bn_mul_sched_if;
    logic         req0;
    logic [255:0] req0_a;
    logic [255:0] req0_b;
    logic         req1;
    logic [255:0] req1_a;
    logic [255:0] req1_b;
    logic         ack0;
    logic         ack1;
    logic         err;
    logic [511:0] res;
    logic         busy;
    logic         mul_reset;
    logic [255:0] mul_a;
    logic [255:0] mul_b;
    logic         mul_done;
    logic [511:0] mul_r;

    modport slave (
        input  req0, req0_a, req0_b, req1, req1_a, req1_b, mul_done, mul_r,
        output ack0, ack1, err, res, busy, mul_reset, mul_a, mul_b
    );

    modport master (
        output req0, req0_a, req0_b, req1, req1_a, req1_b, mul_done, mul_r,
        input  ack0, ack1, err, res, busy, mul_reset, mul_a, mul_b
    );
endinterface

// File: rtl/bn_mul_sched.sv
// Round-robin scheduler sharing one 256x256 multiplier between two requesters.
//   state | meaning
//   IDLE  | multiplier held in reset, arbitrate pending requests
//   START | one extra reset cycle with the granted operands applied
//   RUN   | multiplier running, wait for done or timeout
//   DONE  | ack pulse to owner, result and err valid
module bn_mul_sched #(
    parameter int unsigned MUL_TIMEOUT = 127
) (
    input  logic           clk,
    input  logic           reset,
    bn_mul_sched_if.slave  bus
);
    localparam int unsigned CW = (MUL_TIMEOUT < 2) ? 1 : $clog2(MUL_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [255:0]   mul_a_q, mul_a_d;
    logic [255:0]   mul_b_q, mul_b_d;
    logic [511:0]   res_q, res_d;
    logic           err_q, err_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           busy_q, busy_d;
    logic           mul_reset_q, mul_reset_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_reset_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_q       <= res_d;
            err_q       <= err_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            mul_reset_q <= mul_reset_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        res_d       = res_q;
        err_d       = err_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = busy_q;
        mul_reset_d = mul_reset_q;
        cnt_d       = cnt_q;
        grant_id    = 1'b0;

        case (state_q)
            IDLE: begin
                mul_reset_d = 1'b1;
                if (bus.req0 || bus.req1) begin
                    // on a tie the requester not served last wins
                    grant_id = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    mul_a_d  = grant_id ? bus.req1_a : bus.req0_a;
                    mul_b_d  = grant_id ? bus.req1_b : bus.req0_b;
                    owner_d  = grant_id;
                    last_d   = grant_id;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                mul_reset_d = 1'b0;
                cnt_d       = '0;
                state_d     = RUN;
            end
            RUN: begin
                if (bus.mul_done) begin
                    res_d       = bus.mul_r;
                    err_d       = 1'b0;
                    ack0_d      = ~owner_q;
                    ack1_d      = owner_q;
                    mul_reset_d = 1'b1;
                    state_d     = DONE;
                end else if (cnt_q == CW'(MUL_TIMEOUT)) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    ack0_d      = ~owner_q;
                    ack1_d      = owner_q;
                    mul_reset_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy_d      = 1'b0;
                mul_reset_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err       = err_q;
    assign bus.res       = res_q;
    assign bus.busy      = busy_q;
    assign bus.mul_reset = mul_reset_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_bn_mul_sched.sv
// Scoreboard bench for bn_mul_sched with a behavioural fixed-latency multiplier.
module tb_bn_mul_sched;
    localparam int MD = 64;

    typedef struct {
        logic         id;
        logic [511:0] res;
        logic         err;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    bit   stall;
    int   cyc = 0;
    int   mcnt = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    bn_mul_sched_if bus();

    bn_mul_sched #(.MUL_TIMEOUT(127)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // multiplier: done rises MD cycles after the first non-reset edge, stays high
    always @(posedge clk) begin
        if (bus.mul_reset) mcnt <= 0;
        else if (mcnt < MD) mcnt <= mcnt + 1;
    end
    assign bus.mul_done = !stall && (mcnt >= MD);
    assign bus.mul_r    = bus.mul_done ? ({256'b0, bus.mul_a} * {256'b0, bus.mul_b}) : '0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] prod(input logic [255:0] a, input logic [255:0] b);
        return {256'b0, a} * {256'b0, b};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic raise(input bit id, input logic [255:0] a, input logic [255:0] b,
                         input logic [511:0] er, input bit ee, input int lat);
        exp_t e;
        e.id  = id;
        e.res = er;
        e.err = ee;
        e.cyc = cyc + lat;
        sb.push_back(e);
        if (id) begin
            bus.req1 = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0 = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic wait_ack(input int budget);
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                seen = 1'b1;
                chk("ack_both", 512'(bus.ack0 & bus.ack1), 512'(0));
                chk("sb_nonempty", 512'(sb.size() != 0), 512'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ack_id", 512'(bus.ack1), 512'(e.id));
                    chk("res", bus.res, e.res);
                    chk("err", 512'(bus.err), 512'(e.err));
                    chk("ack_cyc", 512'(cyc), 512'(e.cyc));
                end
                if (bus.ack0) bus.req0 = 1'b0;
                if (bus.ack1) bus.req1 = 1'b0;
            end
        end
        chk("ack_seen", 512'(seen), 512'(1));
    endtask

    initial begin
        logic [255:0] ones;
        logic [511:0] ones_sq;
        logic [255:0] a0, b0, a1, b1;
        int           t;

        ones    = '1;
        ones_sq = {512{1'b1}} - (512'd1 << 257) + 512'd2;
        reset   = 1'b1;
        stall   = 1'b0;
        bus.req0 = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1 = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 512'(bus.busy), 512'(0));
        chk("rst_ack", 512'({bus.ack0, bus.ack1, bus.err}), 512'(0));
        chk("rst_res", bus.res, 512'(0));
        chk("rst_mul_reset", 512'(bus.mul_reset), 512'(1));
        chk("rst_mul_ab", {bus.mul_a, bus.mul_b}, 512'(0));
        reset = 1'b0;
        @(negedge clk);

        // single request from requester 0
        raise(1'b0, 256'd3, 256'd5, 512'd15, 1'b0, 67);
        @(negedge clk);
        chk("start_busy", 512'(bus.busy), 512'(1));
        chk("start_mul_reset", 512'(bus.mul_reset), 512'(1));
        chk("start_mul_a", 512'(bus.mul_a), 512'(3));
        @(negedge clk);
        chk("run_mul_reset", 512'(bus.mul_reset), 512'(0));
        wait_ack(100);
        @(negedge clk);
        chk("idle_busy", 512'(bus.busy), 512'(0));
        chk("res_held", bus.res, 512'd15);
        chk("ack_pulse", 512'({bus.ack0, bus.ack1}), 512'(0));

        // all-ones operands from requester 1
        raise(1'b1, ones, ones, ones_sq, 1'b0, 67);
        wait_ack(100);
        @(negedge clk);

        // contention held from reset: order 0,1 then 0,1 again
        a0 = rnd256(); b0 = rnd256(); a1 = rnd256(); b1 = rnd256();
        reset = 1'b1;
        @(negedge clk);
        raise(1'b0, a0, b0, prod(a0, b0), 1'b0, 68);
        raise(1'b1, a1, b1, prod(a1, b1), 1'b0, 136);
        @(negedge clk);
        reset = 1'b0;
        wait_ack(100);
        wait_ack(100);
        @(negedge clk);
        a0 = rnd256(); b0 = rnd256(); a1 = rnd256(); b1 = rnd256();
        raise(1'b0, a0, b0, prod(a0, b0), 1'b0, 67);
        raise(1'b1, a1, b1, prod(a1, b1), 1'b0, 135);
        wait_ack(100);
        wait_ack(100);
        @(negedge clk);

        // operand change after grant is ignored
        raise(1'b0, 256'd7, 256'd11, 512'd77, 1'b0, 67);
        repeat (5) @(negedge clk);
        bus.req0_a = 256'd99;
        bus.req0_b = 256'd98;
        chk("latched_a_t5", 512'(bus.mul_a), 512'(7));
        repeat (30) @(negedge clk);
        chk("latched_ab_run", {bus.mul_a, bus.mul_b}, {256'd7, 256'd11});
        wait_ack(100);
        @(negedge clk);

        // timeout, then a normal completion
        stall = 1'b1;
        raise(1'b0, 256'd2, 256'd3, 512'd0, 1'b1, 130);
        wait_ack(200);
        stall = 1'b0;
        @(negedge clk);
        raise(1'b1, 256'd4, 256'd6, 512'd24, 1'b0, 67);
        wait_ack(100);
        @(negedge clk);

        // reset mid-RUN abandons the operation
        t = cyc;
        bus.req0 = 1'b1; bus.req0_a = 256'd9; bus.req0_b = 256'd9;
        while (cyc < t + 30) @(negedge clk);
        reset    = 1'b1;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("rst_run_busy", 512'(bus.busy), 512'(0));
        chk("rst_run_mul_reset", 512'(bus.mul_reset), 512'(1));
        chk("rst_run_ack", 512'({bus.ack0, bus.ack1}), 512'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ack", 512'({bus.ack0, bus.ack1}), 512'(0));
        end
        reset = 1'b0;
        @(negedge clk);
        raise(1'b1, 256'd13, 256'd17, 512'd221, 1'b0, 67);
        wait_ack(100);
        @(negedge clk);

        chk("sb_left", 512'(sb.size()), 512'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bn_mul_sched.md
# bn_mul_sched

Round-robin scheduler sharing one 256x256->512-bit unreduced multiplier between two requesters, e.g. point arithmetic and the inversion unit. The block sits between the requesters and the multiplier instance:
- latches one requester's operands;
- restarts the multiplier through its reset pin;
- waits for its done flag, with a timeout;
- returns the 512-bit product with a one-cycle acknowledge.

## Interface
Parameters:
- MUL_TIMEOUT, default 127: maximum cycles spent in RUN before an error completion.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req0  in  1  requester 0 operation request (level).
- req0_a, req0_b  in  256 each  requester 0 operands; held stable while req0 is high and before grant.
- req1  in  1  requester 1 operation request (level).
- req1_a, req1_b  in  256 each  requester 1 operands; same rules as requester 0.
- ack0, ack1  out  1 each  one-cycle completion pulse to the owning requester.
- err  out  1  high with ack when the operation timed out.
- res  out  512  product; valid only in the ack cycle, held afterwards.
- busy  out  1  high in every state except IDLE.
- mul_reset  out  1  drives the multiplier reset; a high cycle restarts it.
- mul_a, mul_b  out  256 each  operands to the multiplier.
- mul_done  in  1  multiplier done flag. It is cleared by mul_reset and stays high once set.
- mul_r  in  512  multiplier product; valid while mul_done is high.

## Operation
- States: IDLE, START, RUN, DONE. All outputs are registered.
- Reset values:
  - state IDLE; ack0, ack1, err, busy = 0; res = 0; mul_a, mul_b = 0.
  - mul_reset = 1, so the multiplier is held in reset.
  - last-served pointer = 1, so requester 0 wins the first tie.
- IDLE:
  - mul_reset = 1.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester not recorded in the last-served pointer.
  - On grant:
    - latch the granted operands into mul_a and mul_b;
    - record the owner;
    - update the last-served pointer;
    - go to START.
- START: mul_reset = 1 for this one cycle, then go to RUN with mul_reset = 0.
- RUN:
  - A timeout counter, cleared on entry, increments every cycle.
  - If mul_done = 1: res <= mul_r, err <= 0, go to DONE.
  - Else if the counter reaches MUL_TIMEOUT: res <= 0, err <= 1, go to DONE.
  - mul_done takes priority if both occur in the same cycle.
- DONE:
  - Pulse the owner's ack for one cycle, with err valid in the same cycle.
  - mul_reset <= 1. Next state is IDLE.
- mul_a and mul_b stay constant from grant until the next grant. Requester operand changes after grant are ignored.
- A requester must drop req in the cycle after its ack. A req still high in IDLE is a new request.
- Ungranted requests wait without limit. Under continuous contention, grants strictly alternate.
- Reset asserted in any state:
  - return to IDLE next cycle with all reset values;
  - the in-flight operation is abandoned and no ack is issued;
  - mul_reset is high during reset.

## Timing
- Requester sampled in IDLE at cycle T (grant):
  - START is cycle T+1;
  - RUN begins at T+2;
  - ack is asserted in cycle T+3+D.
- D is the number of cycles from the last mul_reset-high cycle to the first mul_done-high cycle. For the team's 8x32-bit column multiplier, D = 64, so ack is at T+67.
- Back-to-back operation: the earliest next grant is the cycle after DONE. The minimum request spacing is therefore D+4 cycles.
- busy rises at T+1 and falls in the cycle after DONE.
- Timeout case: ack and err are asserted at T+3+MUL_TIMEOUT.

## Test plan
- Single request, requester 0: req0_a = 3, req0_b = 5, multiplier model with D = 64.
  - Expect ack0 at T+67 with res = 15 and err = 0; ack1 never asserts.
- All-ones operands from requester 1: a = b = 2^256-1.
  - Expect res = 2^512 - 2^257 + 1 on ack1.
- Simultaneous req0 and req1 held high from reset, each dropped after its ack.
  - Expect grant order 0, 1.
  - Re-raise both: expect order 0, 1 again with alternation preserved.
  - Each ack must carry its own product.
- Operand change after grant: requester alters req0_a at T+5.
  - res must reflect the operands latched at T; mul_a must be stable through RUN.
- Timeout: model holds mul_done = 0, MUL_TIMEOUT = 127.
  - Expect ack0 with err = 1 and res = 0 at T+130; the next request completes normally.
- Reset mid-RUN at T+30.
  - Expect no ack, busy = 0 and mul_reset = 1 in the following cycle.
  - A new request afterwards completes at grant+67 with the correct product.
